// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind uart_rx with end-of-line counting and sticky overflow.
// Define UART_RX_FIFO_ECHO_EN to add a one-entry echo register toward uart_tx.
module uart_rx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter logic [7:0]  EOL_CHAR = 8'h0A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rdata,
  input  logic              rvld,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   line_cnt,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        echo_tdata,
  output logic              echo_tvld,
  input  logic              echo_trdy
);

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   line_cnt_q, line_cnt_d;
  logic              overflow_q, overflow_d;

  logic push, pop, drop, push_eol, pop_eol;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a byte.
  assign pop      = rd_en && !empty;
  assign push     = rvld && (!full || pop);
  assign drop     = rvld && full && !pop;
  assign push_eol = push && (rdata == EOL_CHAR);
  assign pop_eol  = pop && (mem_q[rd_ptr_q] == EOL_CHAR);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    line_cnt_d = line_cnt_q;
    unique case ({push_eol, pop_eol})
      2'b10:   line_cnt_d = line_cnt_q + 1'b1;
      2'b01:   line_cnt_d = line_cnt_q - 1'b1;
      default: line_cnt_d = line_cnt_q;
    endcase

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      line_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      line_cnt_q <= line_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rdata;
  end

  assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign line_cnt = line_cnt_q;
  assign overflow = overflow_q;

`ifdef UART_RX_FIFO_ECHO_EN
  logic [7:0] echo_tdata_q;
  logic       echo_tvld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_tvld_q  <= 1'b0;
      echo_tdata_q <= 8'h00;
    end else if (push && (!echo_tvld_q || echo_trdy)) begin
      echo_tvld_q  <= 1'b1;
      echo_tdata_q <= rdata;
    end else if (echo_tvld_q && echo_trdy) begin
      echo_tvld_q  <= 1'b0;
    end
  end

  assign echo_tvld  = echo_tvld_q;
  assign echo_tdata = echo_tdata_q;
`else
  logic unused_echo_trdy;
  assign unused_echo_trdy = echo_trdy;
  assign echo_tvld        = 1'b0;
  assign echo_tdata       = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a queue-based reference model.
// Build with UART_RX_FIFO_ECHO_EN defined to also check the echo path.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam logic [7:0] EOL = 8'h0A;

  logic       tb_clk = 1'b0;
  logic       rst_n;
  logic [7:0] rdata;
  logic       rvld, rd_en, ovf_clr, echo_trdy;
  logic [7:0] rd_data, echo_tdata;
  logic       empty, full, overflow, echo_tvld;
  logic [4:0] count, line_cnt;

  uart_rx_fifo dut (
    .clk        (tb_clk),
    .rst_n      (rst_n),
    .rdata      (rdata),
    .rvld       (rvld),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .line_cnt   (line_cnt),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .echo_tdata (echo_tdata),
    .echo_tvld  (echo_tvld),
    .echo_trdy  (echo_trdy)
  );

  always #5 tb_clk = ~tb_clk;

  // Reference model: FIFO contents as a queue, plus sticky flag and echo slot.
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_ev;
  logic [7:0] m_ed;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_lines();
    int n = 0;
    foreach (mq[i]) if (mq[i] == EOL) n++;
    return n;
  endfunction

  task automatic check_all();
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("line_cnt", 32'(line_cnt), 32'(model_lines()));
    check_eq("empty", 32'(empty), 32'(mq.size() == 0));
    check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
`ifdef UART_RX_FIFO_ECHO_EN
    check_eq("echo_tvld", 32'(echo_tvld), 32'(m_ev));
    check_eq("echo_tdata", 32'(echo_tdata), 32'(m_ed));
`else
    check_eq("echo_tvld", 32'(echo_tvld), 32'h0);
    check_eq("echo_tdata", 32'(echo_tdata), 32'h0);
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_ev  = 0;
    m_ed  = 8'h00;
  endtask

  // One clock: drive inputs, advance model across the edge, then compare.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c,
                       input logic t);
    int  sz;
    bit  p_pop, p_push, p_drop;
    rvld = v; rdata = d; rd_en = r; ovf_clr = c; echo_trdy = t;
    @(posedge tb_clk);
    sz     = mq.size();
    p_pop  = r && (sz > 0);
    p_push = v && ((sz < DEPTH) || p_pop);
    p_drop = v && (sz == DEPTH) && !p_pop;
    if (p_pop)  void'(mq.pop_front());
    if (p_push) mq.push_back(d);
    if (p_drop) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (p_push && (!m_ev || t)) begin
      m_ev = 1;
      m_ed = d;
    end else if (m_ev && t) begin
      m_ev = 0;
    end
    #1;
    rvld = 0; rd_en = 0; ovf_clr = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge tb_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] help_str [5];
    help_str[0] = 8'h68; help_str[1] = 8'h65; help_str[2] = 8'h6C;
    help_str[3] = 8'h70; help_str[4] = 8'h0A;
    rvld = 0; rdata = 0; rd_en = 0; ovf_clr = 0; echo_trdy = 0;
    rst_n = 1'b1;
    model_reset();
    @(posedge tb_clk);
    #1;
    do_reset();

    // "help\n", one byte every 4 cycles, then drain.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, help_str[i], 1'b0, 1'b0, 1'b0);
      idle(3);
    end
    check_eq("help_count", 32'(count), 32'd5);
    check_eq("help_lines", 32'(line_cnt), 32'd1);
    check_eq("help_head", 32'(rd_data), 32'h68);
    for (int i = 0; i < 5; i++) begin
      check_eq("help_pop", 32'(rd_data), 32'(help_str[i]));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    end
    check_eq("help_empty", 32'(empty), 32'd1);
    check_eq("help_lines0", 32'(line_cnt), 32'd0);

    // Fill, then drop 0xAA.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    check_eq("ovf_full", 32'(full), 32'd1);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("ovf_pop", 32'(rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    end
    check_eq("ovf_drained", 32'(empty), 32'd1);

    // Pop on empty is ignored; clear overflow.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("empty_pop", 32'(count), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_clr", 32'(overflow), 32'd0);

    // Simultaneous push/pop at full, then wrap 40 bytes through.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, EOL, 1'b1, 1'b0, 1'b1);
    check_eq("full_pp_count", 32'(count), 32'd16);
    check_eq("full_pp_ovf", 32'(overflow), 32'd0);
    check_eq("full_pp_lines", 32'(line_cnt), 32'd1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Drop and ovf_clr together: set wins.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    check_eq("ovf_set_wins", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);

    // EOL pushed and popped in the same cycle.
    cycle(1'b1, EOL, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, EOL, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, EOL, 1'b1, 1'b0, 1'b1);
    check_eq("eol_pp_lines", 32'(line_cnt), 32'd2);

    // Echo: stalled sink keeps the first byte only.
    do_reset();
    cycle(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    idle(2);
    cycle(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    check_eq("echo_fifo", 32'(count), 32'd2);
`ifdef UART_RX_FIFO_ECHO_EN
    check_eq("echo_first", 32'(echo_tdata), 32'h61);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("echo_fall", 32'(echo_tvld), 32'd0);
`else
    check_eq("echo_off", 32'(echo_tvld), 32'd0);
`endif

    // Randomized phases: fill-biased then drain-biased.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 400; i++) begin
        logic       v, r, c, t;
        logic [7:0] d;
        v = ((ph % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        r = ((ph % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        d = ($urandom_range(0, 3) == 0) ? EOL : 8'($urandom);
        c = ($urandom_range(0, 15) == 0);
        t = 1'($urandom);
        cycle(v, d, r, c, t);
      end
    end

    // Reset mid-operation discards contents.
    for (int i = 0; i < 5; i++) cycle(1'b1, EOL, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_eq("rst_mid_count", 32'(count), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
